// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch-stage header: widths, ranges, FSM encoding, NOP
`ifndef INSTR_FETCH_PKG_DEFS
`define INSTR_FETCH_PKG_DEFS
`define PC_RANGE   31:0
`define DATA_RANGE 31:0
`endif

package instr_fetch_pkg;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DROP
  } if_state_e;

  function automatic logic [PC_W-1:0] pc_next(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction
endpackage

// File: rtl/if_skid_buf.sv
// rtl/if_skid_buf.sv - one-entry {pc, instruction} skid buffer with synchronous clear
module if_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_wr,
  input  logic [63:0] i_wdata,
  input  logic        i_rd,
  output logic        o_valid,
  output logic [63:0] o_rdata
);
  logic        r_valid;
  logic [63:0] r_data;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_valid <= 1'b1;
    end else if (i_rd) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_wr && !i_clr) begin
      r_data <= i_wdata;
    end
  end

  assign o_valid = r_valid;
  assign o_rdata = r_data;
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage, one outstanding bus request, IF->ID registers
// IF_MISALIGN_CHK_EN adds if2id_misalign and reports misaligned redirects instead of fetching.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [`PC_RANGE] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ibus_req,
  output logic [`PC_RANGE]   ibus_addr,
  input  logic               ibus_ready,
  input  logic               ibus_rvalid,
  input  logic [`DATA_RANGE] ibus_rdata,
  input  logic               branch_take,
  input  logic [`PC_RANGE]   branch_target,
  input  logic               id_stall,
`ifdef IF_MISALIGN_CHK_EN
  output logic               if2id_misalign,
`endif
  output logic               if2id_valid,
  output logic [`PC_RANGE]   if2id_pc,
  output logic [`DATA_RANGE] if2id_instruction
);
  if_state_e          r_state;
  logic [`PC_RANGE]   r_pc;
  logic [`PC_RANGE]   r_fetch_pc;
  logic               r_req;
  logic               r_if2id_valid;
  logic [`PC_RANGE]   r_if2id_pc;
  logic [`DATA_RANGE] r_if2id_instr;
  logic               w_accept;
  logic               w_still_out;
  logic               w_misalign;
  logic               w_parked;
  logic [`PC_RANGE]   w_target;
  logic               w_skid_wr;
  logic               w_skid_rd;
  logic               w_skid_valid;
  logic [63:0]        w_skid_rdata;

  assign w_accept = r_req && ibus_ready;
  // a request is still in flight after this edge unless its response lands on it
  assign w_still_out = w_accept ||
                       (((r_state == S_WAIT) || (r_state == S_DROP)) && !ibus_rvalid);

`ifdef IF_MISALIGN_CHK_EN
  logic r_parked;
  logic r_misalign;
  assign w_target       = branch_target;
  assign w_misalign     = |branch_target[1:0];
  assign w_parked       = r_parked;
  assign if2id_misalign = r_misalign;
`else
  assign w_target   = branch_target & 32'hFFFF_FFFC;
  assign w_misalign = 1'b0;
  assign w_parked   = 1'b0;
`endif

  assign w_skid_wr = !branch_take && (r_state == S_WAIT) && ibus_rvalid && id_stall;
  assign w_skid_rd = !branch_take && (r_state == S_HOLD) && !id_stall;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (branch_take),
    .i_wr    (w_skid_wr),
    .i_wdata ({r_fetch_pc, ibus_rdata}),
    .i_rd    (w_skid_rd),
    .o_valid (w_skid_valid),
    .o_rdata (w_skid_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_fetch_pc    <= '0;
      r_req         <= 1'b0;
      r_if2id_valid <= 1'b0;
      r_if2id_pc    <= '0;
      r_if2id_instr <= NOP;
`ifdef IF_MISALIGN_CHK_EN
      r_parked      <= 1'b0;
      r_misalign    <= 1'b0;
`endif
    end else begin
      if (!id_stall) begin
        r_if2id_valid <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        r_misalign    <= 1'b0;
`endif
      end
      if (branch_take) begin
        r_pc          <= w_target;
        r_if2id_valid <= 1'b0;
        if (w_misalign) begin
          r_state       <= S_IDLE;
          r_req         <= 1'b0;
          r_if2id_valid <= 1'b1;
          r_if2id_pc    <= w_target;
          r_if2id_instr <= NOP;
`ifdef IF_MISALIGN_CHK_EN
          r_parked      <= 1'b1;
          r_misalign    <= 1'b1;
`endif
        end else begin
          r_state <= w_still_out ? S_DROP : S_FETCH;
          r_req   <= !w_still_out;
`ifdef IF_MISALIGN_CHK_EN
          r_parked   <= 1'b0;
          r_misalign <= 1'b0;
`endif
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!w_parked) begin
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end
          end
          S_FETCH: begin
            if (w_accept) begin
              r_pc       <= pc_next(r_pc);
              r_fetch_pc <= r_pc;
              r_req      <= 1'b0;
              r_state    <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (ibus_rvalid) begin
              if (!id_stall) begin
                r_if2id_valid <= 1'b1;
                r_if2id_pc    <= r_fetch_pc;
                r_if2id_instr <= ibus_rdata;
                r_state       <= S_FETCH;
                r_req         <= 1'b1;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (!id_stall && w_skid_valid) begin
              r_if2id_valid                 <= 1'b1;
              {r_if2id_pc, r_if2id_instr}   <= w_skid_rdata;
              r_state                       <= S_FETCH;
              r_req                         <= 1'b1;
            end
          end
          S_DROP: begin
            if (ibus_rvalid) begin
              r_state <= S_FETCH;
              r_req   <= 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ibus_req          = r_req;
  assign ibus_addr         = r_pc;
  assign if2id_valid       = r_if2id_valid;
  assign if2id_pc          = r_if2id_pc;
  assign if2id_instruction = r_if2id_instr;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed self-checking bench for instr_fetch (IF_MISALIGN_CHK_EN aware)
`timescale 1ns/1ps
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready = 1'b0;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic        branch_take = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        id_stall = 1'b0;
  logic        if2id_valid;
  logic [31:0] if2id_pc;
  logic [31:0] if2id_instruction;
`ifdef IF_MISALIGN_CHK_EN
  logic        if2id_misalign;
`endif
  logic        resp_en = 1'b1;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .ibus_req          (ibus_req),
    .ibus_addr         (ibus_addr),
    .ibus_ready        (ibus_ready),
    .ibus_rvalid       (ibus_rvalid),
    .ibus_rdata        (ibus_rdata),
    .branch_take       (branch_take),
    .branch_target     (branch_target),
    .id_stall          (id_stall),
`ifdef IF_MISALIGN_CHK_EN
    .if2id_misalign    (if2id_misalign),
`endif
    .if2id_valid       (if2id_valid),
    .if2id_pc          (if2id_pc),
    .if2id_instruction (if2id_instruction)
  );

  // bus model: one response per accepted request, word = 0xAAAA0000 + addr/4 + 1
  always @(posedge clk) begin
    if (ibus_req && ibus_ready) begin
      pend      <= 1'b1;
      pend_addr <= ibus_addr;
    end else if (ibus_rvalid) begin
      pend <= 1'b0;
    end
  end
  assign ibus_rvalid = pend && resp_en;
  assign ibus_rdata  = 32'hAAAA_0000 + (pend_addr >> 2) + 32'd1;

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ibus_ready = 1'b1; resp_en = 1'b1;
    step(2);
    n_cmp++;
    if ({ibus_req, if2id_valid, if2id_pc, if2id_instruction, ibus_addr} !==
        {1'b0, 1'b0, 32'h0, 32'h13, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: got req=%b valid=%b pc=%h instr=%h addr=%h want 0 0 00000000 00000013 00000000",
               ibus_req, if2id_valid, if2id_pc, if2id_instruction, ibus_addr);
    end
`ifdef IF_MISALIGN_CHK_EN
    n_cmp++;
    if (if2id_misalign !== 1'b0) begin
      n_err++; $display("FAIL reset_misalign: got %b want 0", if2id_misalign);
    end
`endif
    rst = 1'b0;
    step();
    n_cmp++;
    if ({ibus_req, ibus_addr} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL idle_to_fetch: got req=%b addr=%h want 1 00000000", ibus_req, ibus_addr);
    end
  endtask

  task automatic test_zero_wait();
    step();
    n_cmp++;
    if ({ibus_req, if2id_valid} !== 2'b00) begin
      n_err++; $display("FAIL zw_wait: got req=%b valid=%b want 0 0", ibus_req, if2id_valid);
    end
    step();
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h0, 32'hAAAA_0001}) begin
      n_err++; $display("FAIL zw_first: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h0, 32'hAAAA_0001});
    end
    step();
    n_cmp++;
    if (if2id_valid !== 1'b0) begin
      n_err++; $display("FAIL zw_gap: got valid=%b want 0", if2id_valid);
    end
    step();
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h4, 32'hAAAA_0002}) begin
      n_err++; $display("FAIL zw_second: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h4, 32'hAAAA_0002});
    end
    ibus_ready = 1'b0;
  endtask

  task automatic test_ready_low();
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({ibus_req, ibus_addr} !== {1'b1, 32'h8}) begin
        n_err++; $display("FAIL ready_low_%0d: got req=%b addr=%h want 1 00000008", i, ibus_req, ibus_addr);
      end
    end
    ibus_ready = 1'b1;
    step(2);
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h8, 32'hAAAA_0003}) begin
      n_err++; $display("FAIL ready_resume: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h8, 32'hAAAA_0003});
    end
    step(2);
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'hC, 32'hAAAA_0004}) begin
      n_err++; $display("FAIL ready_next: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'hC, 32'hAAAA_0004});
    end
  endtask

  task automatic test_stall();
    id_stall = 1'b1;
    step();
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'hC, 32'hAAAA_0004}) begin
      n_err++; $display("FAIL stall_hold_wait: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'hC, 32'hAAAA_0004});
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if ({ibus_req, if2id_valid, if2id_pc, if2id_instruction} !== {1'b0, 1'b1, 32'hC, 32'hAAAA_0004}) begin
        n_err++; $display("FAIL stall_hold_%0d: got %h want %h", i, {ibus_req, if2id_valid, if2id_pc, if2id_instruction}, {1'b0, 1'b1, 32'hC, 32'hAAAA_0004});
      end
    end
    id_stall = 1'b0;
    step();
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction, ibus_req, ibus_addr} !== {1'b1, 32'h10, 32'hAAAA_0005, 1'b1, 32'h14}) begin
      n_err++; $display("FAIL stall_release: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction, ibus_req, ibus_addr}, {1'b1, 32'h10, 32'hAAAA_0005, 1'b1, 32'h14});
    end
  endtask

  task automatic test_branch_wait();
    resp_en = 1'b0;
    step();
    branch_take = 1'b1; branch_target = 32'h100;
    step();
    branch_take = 1'b0;
    n_cmp++;
    if ({if2id_valid, ibus_req} !== 2'b00) begin
      n_err++; $display("FAIL br_wait_drop: got valid=%b req=%b want 0 0", if2id_valid, ibus_req);
    end
    resp_en = 1'b1;
    step();
    n_cmp++;
    if ({if2id_valid, ibus_req, ibus_addr} !== {1'b0, 1'b1, 32'h100}) begin
      n_err++; $display("FAIL br_wait_refetch: got valid=%b req=%b addr=%h want 0 1 00000100", if2id_valid, ibus_req, ibus_addr);
    end
    step(2);
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h100, 32'hAAAA_0041}) begin
      n_err++; $display("FAIL br_wait_target: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h100, 32'hAAAA_0041});
    end
  endtask

  task automatic test_branch_accept_stall();
    branch_take = 1'b1; branch_target = 32'h200; id_stall = 1'b1;
    step();
    branch_take = 1'b0;
    n_cmp++;
    if ({if2id_valid, ibus_req} !== 2'b00) begin
      n_err++; $display("FAIL br_acc_redirect: got valid=%b req=%b want 0 0", if2id_valid, ibus_req);
    end
    step();
    n_cmp++;
    if ({if2id_valid, ibus_req, ibus_addr} !== {1'b0, 1'b1, 32'h200}) begin
      n_err++; $display("FAIL br_acc_refetch: got valid=%b req=%b addr=%h want 0 1 00000200", if2id_valid, ibus_req, ibus_addr);
    end
    id_stall = 1'b0;
    step();
    n_cmp++;
    if (if2id_valid !== 1'b0) begin
      n_err++; $display("FAIL br_acc_no_old: got valid=%b pc=%h want valid 0", if2id_valid, if2id_pc);
    end
    step();
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h200, 32'hAAAA_0081}) begin
      n_err++; $display("FAIL br_acc_target: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h200, 32'hAAAA_0081});
    end
  endtask

`ifdef IF_MISALIGN_CHK_EN
  task automatic test_misalign();
    ibus_ready = 1'b0; branch_take = 1'b1; branch_target = 32'h102;
    step();
    branch_take = 1'b0;
    n_cmp++;
    if ({ibus_req, if2id_valid, if2id_misalign, if2id_pc, if2id_instruction} !== {1'b0, 1'b1, 1'b1, 32'h102, 32'h13}) begin
      n_err++; $display("FAIL misalign_report: got %h want %h", {ibus_req, if2id_valid, if2id_misalign, if2id_pc, if2id_instruction}, {1'b0, 1'b1, 1'b1, 32'h102, 32'h13});
    end
    ibus_ready = 1'b1;
    step(3);
    n_cmp++;
    if ({ibus_req, if2id_valid, if2id_misalign} !== 3'b000) begin
      n_err++; $display("FAIL misalign_parked: got req=%b valid=%b mis=%b want 0 0 0", ibus_req, if2id_valid, if2id_misalign);
    end
    branch_take = 1'b1; branch_target = 32'h300;
    step();
    branch_take = 1'b0;
    n_cmp++;
    if ({ibus_req, ibus_addr} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL misalign_exit: got req=%b addr=%h want 1 00000300", ibus_req, ibus_addr);
    end
    step(2);
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h300, 32'hAAAA_00C1}) begin
      n_err++; $display("FAIL misalign_resume: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h300, 32'hAAAA_00C1});
    end
  endtask
`else
  task automatic test_target_align();
    branch_take = 1'b1; branch_target = 32'h303;
    step();
    branch_take = 1'b0;
    step();
    n_cmp++;
    if ({ibus_req, ibus_addr} !== {1'b1, 32'h300}) begin
      n_err++; $display("FAIL align_force: got req=%b addr=%h want 1 00000300", ibus_req, ibus_addr);
    end
    step(2);
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h300, 32'hAAAA_00C1}) begin
      n_err++; $display("FAIL align_target: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h300, 32'hAAAA_00C1});
    end
  endtask
`endif

  task automatic test_reset_abandon();
    resp_en = 1'b0;
    step();
    rst = 1'b1; ibus_ready = 1'b0;
    step();
    rst = 1'b0; resp_en = 1'b1;
    n_cmp++;
    if ({ibus_req, if2id_valid, if2id_pc, if2id_instruction, ibus_addr} !== {1'b0, 1'b0, 32'h0, 32'h13, 32'h0}) begin
      n_err++; $display("FAIL abandon_reset: got %h want %h", {ibus_req, if2id_valid, if2id_pc, if2id_instruction, ibus_addr}, {1'b0, 1'b0, 32'h0, 32'h13, 32'h0});
    end
    step();
    n_cmp++;
    if ({ibus_req, if2id_valid, ibus_addr} !== {1'b1, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL abandon_late_resp: got req=%b valid=%b addr=%h want 1 0 00000000", ibus_req, if2id_valid, ibus_addr);
    end
    ibus_ready = 1'b1;
    step(2);
    n_cmp++;
    if ({if2id_valid, if2id_pc, if2id_instruction} !== {1'b1, 32'h0, 32'hAAAA_0001}) begin
      n_err++; $display("FAIL abandon_restart: got %h want %h", {if2id_valid, if2id_pc, if2id_instruction}, {1'b1, 32'h0, 32'hAAAA_0001});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_ready_low();
    test_stall();
    test_branch_wait();
    test_branch_accept_stall();
`ifdef IF_MISALIGN_CHK_EN
    test_misalign();
`else
    test_target_align();
`endif
    test_reset_abandon();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter RESET_PC SHALL default to 32'h0000_0000 and give the first fetch address after reset.
REQ-003 Port clk SHALL be input, 1 bit, the core clock.
REQ-004 Port rst SHALL be input, 1 bit, the synchronous active-high reset.
REQ-005 Port ibus_req SHALL be output, 1 bit, the instruction-bus request valid.
REQ-006 Port ibus_addr SHALL be output, 32 bits, the fetch address.
REQ-007 Port ibus_ready SHALL be input, 1 bit; the bus accepts the request when ibus_req && ibus_ready.
REQ-008 Port ibus_rvalid SHALL be input, 1 bit, the response valid; responses are in order, at least 1 cycle after accept.
REQ-009 Port ibus_rdata SHALL be input, 32 bits, the instruction word.
REQ-010 Port branch_take SHALL be input, 1 bit, the redirect request from a downstream stage.
REQ-011 Port branch_target SHALL be input, 32 bits, the redirect address.
REQ-012 Port id_stall SHALL be input, 1 bit; the decode stage cannot accept a new instruction.
REQ-013 Port if2id_valid SHALL be output, 1 bit, a registered flag marking the instruction valid.
REQ-014 Port if2id_pc SHALL be output, 32 bits, the registered PC of the instruction.
REQ-015 Port if2id_instruction SHALL be output, 32 bits, the registered instruction.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, WAIT, HOLD and DROP, with at most one outstanding bus request.
REQ-017 IDLE SHALL move to FETCH unconditionally on the next cycle.
REQ-018 In FETCH, ibus_req SHALL be 1 and ibus_addr SHALL be pc_q, held stable until accept.
REQ-019 On accept, pc_q SHALL become pc_q+4 (modulo 2^32) and the state SHALL become WAIT.
REQ-020 In WAIT, on ibus_rvalid with id_stall=0:
- if2id_{valid,pc,instruction} SHALL become {1, fetched PC, ibus_rdata};
- the state SHALL become FETCH.
REQ-021 In WAIT, on ibus_rvalid with id_stall=1, the response SHALL be stored in a 1-entry skid buffer and the state SHALL become HOLD.
REQ-022 In HOLD, ibus_req SHALL be 0; when id_stall=0, the buffer SHALL move to the if2id registers and the state SHALL become FETCH.
REQ-023 While id_stall=1, the if2id registers SHALL hold their value.
REQ-024 When id_stall=0 and no new instruction is written, if2id_valid SHALL become 0 on the next edge.
REQ-025 branch_take SHALL have priority over stall and response, with these effects on the next edge:
- pc_q SHALL become branch_target;
- if2id_valid SHALL become 0;
- the skid buffer SHALL be cleared.
REQ-026 After a redirect, the state SHALL be DROP if a request is outstanding, including one accepted in the same cycle; otherwise it SHALL be FETCH.
REQ-027 In DROP, ibus_req SHALL be 0, the next ibus_rvalid SHALL be discarded, and the state SHALL then become FETCH.
REQ-028 An ibus_rvalid with no request outstanding SHALL be ignored.
REQ-029 Throughput SHALL be one instruction per 2 cycles with a zero-wait bus.

Reset
REQ-030 On reset, the block SHALL load these values and enter IDLE:
- state=IDLE, pc_q=RESET_PC, ibus_req=0;
- if2id_valid=0, if2id_pc=0, if2id_instruction=32'h0000_0013 (NOP);
- skid buffer empty.
REQ-031 Reset mid-transaction SHALL abandon the outstanding request, and its late response SHALL be ignored per REQ-028.

Configuration
REQ-032 When macro IF_MISALIGN_CHK_EN is defined:
- a 1-bit output if2id_misalign SHALL exist;
- a branch_target with bits [1:0]!=0 SHALL produce if2id_valid=1, if2id_misalign=1, if2id_pc=target, if2id_instruction=NOP, with no bus request;
- the FSM SHALL then wait in IDLE for the next branch_take.
REQ-033 When IF_MISALIGN_CHK_EN is undefined, the port SHALL be absent and branch_target[1:0] SHALL be forced to 2'b00.

Structure
REQ-034 The FSM state encoding, the NOP constant (32'h0000_0013) and the PC/data widths SHALL be defined in the shared core header alongside PC_RANGE and DATA_RANGE.
REQ-035 The skid buffer SHALL be a sub-module named if_skid_buf (1 entry, 64-bit payload, with clear).

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- Reset, then zero-wait bus returning 0xAAAA0001, 0xAAAA0002 -> if2id_pc 0x0, 0x4 with those words; if2id_valid toggles 1,0,1.
- ibus_ready low for 3 cycles at pc=0x8 -> ibus_addr holds 0x8 and ibus_req holds 1 throughout.
- id_stall=1 when the response for pc=0x10 arrives -> if2id is unchanged and HOLD has no ibus_req; after stall drops, if2id_pc=0x10 on the next edge.
- branch_take to 0x100 while in WAIT -> if2id_valid=0, the stale response is dropped, and the next ibus_addr=0x100.
- branch_take coinciding with both the accept and a stall -> the redirect wins and no instruction from the old path is presented.
- With IF_MISALIGN_CHK_EN: branch_target 0x102 -> if2id_misalign=1, if2id_pc=0x102, and no ibus_req.
